// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding the I2S DAC driver: pushes L/R pairs from the synth engine
// and pops one pair per DACLRCK frame, holding it stable for the whole frame.
module audio_sample_fifo #(
   parameter int AUD_BIT_DEPTH   = 24,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                       sys_clk,
   input  logic                       reset_reg,
   input  logic                       i_sample_valid,
   output logic                       o_sample_ready,
   input  logic [AUD_BIT_DEPTH-1:0]   i_lsample,
   input  logic [AUD_BIT_DEPTH-1:0]   i_rsample,
   input  logic                       iAUD_DACLRCK,
   output logic [AUD_BIT_DEPTH-1:0]   o_lsound_out,
   output logic [AUD_BIT_DEPTH-1:0]   o_rsound_out,
   output logic                       o_frame_strobe,
   output logic [FIFO_DEPTH_LOG2:0]   o_fifo_level,
   output logic [7:0]                 o_underrun_cnt
);

   localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
   localparam int LW    = FIFO_DEPTH_LOG2 + 1;
   localparam logic [LW-1:0]              LEVEL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0]              LEVEL_ONE  = LW'(1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

   logic [SYNC_STAGES-1:0]     lr_sync;
   logic                       lr_s;
   logic                       lr_d;
   logic                       frame;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [LW-1:0]              level_next;
   logic                       empty;
   logic                       push;
   logic                       pop;
   logic [AUD_BIT_DEPTH-1:0]   mem_l [DEPTH];
   logic [AUD_BIT_DEPTH-1:0]   mem_r [DEPTH];

   assign lr_s  = lr_sync[SYNC_STAGES-1];
   // Falling LRCK marks the start of the left word, i.e. a new frame.
   assign frame = lr_d & ~lr_s;
   assign empty = (o_fifo_level == '0);

   // Handshake: a pair transfers on any posedge where i_sample_valid && o_sample_ready;
   // valid may be held while ready is low and the pair stays on the inputs until taken.
   assign push  = i_sample_valid & o_sample_ready;
   assign pop   = frame & ~empty;

   always_comb begin
      level_next = o_fifo_level;
      if (push && !pop) begin
         level_next = o_fifo_level + LEVEL_ONE;
      end else if (pop && !push) begin
         level_next = o_fifo_level - LEVEL_ONE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset_reg) begin
         lr_sync        <= '0;
         lr_d           <= 1'b0;
         o_frame_strobe <= 1'b0;
      end else begin
         lr_sync        <= {lr_sync[SYNC_STAGES-2:0], iAUD_DACLRCK};
         lr_d           <= lr_s;
         o_frame_strobe <= frame;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset_reg) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         o_fifo_level   <= '0;
         o_sample_ready <= 1'b0;
         o_lsound_out   <= '0;
         o_rsound_out   <= '0;
         o_underrun_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         o_fifo_level   <= level_next;
         o_sample_ready <= (level_next != LEVEL_FULL);
         // A frame with nothing stored mutes the outputs rather than repeating the last pair.
         if (frame) begin
            if (!empty) begin
               o_lsound_out <= mem_l[rd_ptr];
               o_rsound_out <= mem_r[rd_ptr];
            end else begin
               o_lsound_out <= '0;
               o_rsound_out <= '0;
               if (o_underrun_cnt != 8'hFF) begin
                  o_underrun_cnt <= o_underrun_cnt + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push && !reset_reg) begin
         mem_l[wr_ptr] <= i_lsample;
         mem_r[wr_ptr] <= i_rsample;
      end
   end

endmodule
